// File: rtl/acc_mem_pkg.sv
// Shared types and sizing for the accelerator memory responder.
package acc_mem_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RDONE,
        WRITE,
        WDONE
    } acc_state_e;

endpackage

// File: rtl/acc_line_assembler.sv
// Collects indexed 32-bit words into a working line and publishes the full line on the last word,
// so the visible line stays stable while the next one is being gathered.
module acc_line_assembler
    import acc_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic [3:0]        cap_idx,
    input  logic              cap_last,
    input  logic [WORD_W-1:0] cap_word,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] work_q;
    logic [LINE_W-1:0] work_nx;
    logic [3:0]        slot;

    // Word 0 lands in the most significant slot (big-endian line order).
    always_comb begin
        slot    = 4'(LINE_WORDS - 1) - cap_idx;
        work_nx = work_q;
        work_nx[int'(slot) * WORD_W +: WORD_W] = cap_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            line   <= '0;
        end else if (cap_en) begin
            work_q <= work_nx;
            if (cap_last) begin
                line <= work_nx;
            end
        end
    end

endmodule

// File: rtl/acc_mem_responder.sv
// Memory-side responder: shares one SRAM port between the CPU (always granted) and the
// accelerator's line reads / word writes, and mirrors in-window CPU writes onto the listen bus.
//
// state | meaning
// IDLE  | waiting; read slot served before write slot
// READ  | issue 16 word reads, capture returning words into the line
// RDONE | line complete, read_data_valid pulse
// WRITE | write the held word on the first cycle the CPU is not using the SRAM
// WDONE | write_done pulse
module acc_mem_responder
    import acc_mem_pkg::*;
#(
    parameter logic [15:0] LISTEN_LO = 16'h0000,
    parameter logic [15:0] LISTEN_HI = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_en,
    input  logic         cpu_we,
    input  logic [15:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_rvalid,
    input  logic         mem_acc_read_en,
    input  logic [15:0]  mem_acc_read_addr,
    output logic [511:0] mem_acc_read_data,
    output logic         mem_acc_read_data_valid,
    input  logic         mem_acc_write_en,
    input  logic [15:0]  mem_acc_write_addr,
    input  logic [31:0]  mem_acc_write_data,
    output logic         mem_acc_write_done,
    output logic         mem_listen_en,
    output logic [15:0]  mem_listen_addr,
    output logic [31:0]  mem_listen_data,
    output logic         sram_en,
    output logic         sram_we,
    output logic [15:0]  sram_addr,
    output logic [31:0]  sram_wdata,
    input  logic [31:0]  sram_rdata,
    output logic         req_overflow
);

    acc_state_e  state_q, state_nx;
    logic        rd_full, wr_full;
    logic [15:0] rd_addr, wr_addr, wr_cur_addr, rd_start;
    logic [31:0] wr_data, wr_cur_data;
    logic [4:0]  issue_cnt, recv_cnt;
    logic        acc_pend;
    logic        rd_take, wr_take, issue, wr_go, cap_last;
    logic [16:0] lo_diff, hi_diff;
    logic        listen_hit;

    // Window test via borrow bits keeps the compare free of constant-range corner cases.
    assign lo_diff    = {1'b0, cpu_addr} - {1'b0, LISTEN_LO};
    assign hi_diff    = {1'b0, LISTEN_HI} - {1'b0, cpu_addr};
    assign listen_hit = cpu_en & cpu_we & ~lo_diff[16] & ~hi_diff[16];
    assign cpu_rdata  = sram_rdata;
    assign cap_last   = acc_pend && (recv_cnt == 5'(LINE_WORDS - 1));

    always_comb begin
        state_nx                = state_q;
        rd_take                 = 1'b0;
        wr_take                 = 1'b0;
        issue                   = 1'b0;
        wr_go                   = 1'b0;
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_full) begin
                    state_nx = READ;
                    rd_take  = 1'b1;
                end else if (wr_full) begin
                    state_nx = WRITE;
                    wr_take  = 1'b1;
                end
            end
            READ: begin
                issue = !cpu_en && (issue_cnt < 5'(LINE_WORDS));
                if (cap_last) begin
                    state_nx = RDONE;
                end
            end
            RDONE: begin
                mem_acc_read_data_valid = 1'b1;
                state_nx                = IDLE;
            end
            WRITE: begin
                if (!cpu_en) begin
                    wr_go    = 1'b1;
                    state_nx = WDONE;
                end
            end
            WDONE: begin
                mem_acc_write_done = 1'b1;
                state_nx           = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // CPU path is gated by rst_n so the SRAM port is quiet while reset is held.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (cpu_en && rst_n) begin
            sram_en    = 1'b1;
            sram_we    = cpu_we;
            sram_addr  = cpu_addr;
            sram_wdata = cpu_wdata;
        end else if (issue) begin
            sram_en   = 1'b1;
            sram_addr = rd_start + 16'(issue_cnt);
        end else if (wr_go) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = wr_cur_addr;
            sram_wdata = wr_cur_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_full         <= 1'b0;
            rd_addr         <= '0;
            rd_start        <= '0;
            wr_full         <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            wr_cur_addr     <= '0;
            wr_cur_data     <= '0;
            issue_cnt       <= '0;
            recv_cnt        <= '0;
            acc_pend        <= 1'b0;
            req_overflow    <= 1'b0;
            cpu_rvalid      <= 1'b0;
            mem_listen_en   <= 1'b0;
            mem_listen_addr <= '0;
            mem_listen_data <= '0;
        end else begin
            state_q    <= state_nx;
            acc_pend   <= issue;
            cpu_rvalid <= cpu_en & ~cpu_we;

            if (rd_take) begin
                rd_full   <= 1'b0;
                rd_start  <= rd_addr;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else begin
                if (issue)    issue_cnt <= issue_cnt + 5'd1;
                if (acc_pend) recv_cnt  <= recv_cnt + 5'd1;
            end

            if (wr_take) begin
                wr_full     <= 1'b0;
                wr_cur_addr <= wr_addr;
                wr_cur_data <= wr_data;
            end

            // A slot freed on this edge may be refilled by a pulse in the same cycle.
            if (mem_acc_read_en) begin
                if (rd_full && !rd_take) begin
                    req_overflow <= 1'b1;
                end else begin
                    rd_full <= 1'b1;
                    rd_addr <= mem_acc_read_addr;
                end
            end

            if (mem_acc_write_en) begin
                if (wr_full && !wr_take) begin
                    req_overflow <= 1'b1;
                end else begin
                    wr_full <= 1'b1;
                    wr_addr <= mem_acc_write_addr;
                    wr_data <= mem_acc_write_data;
                end
            end

            mem_listen_en <= listen_hit;
            if (listen_hit) begin
                mem_listen_addr <= cpu_addr;
                mem_listen_data <= cpu_wdata;
            end
        end
    end

    acc_line_assembler u_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en   (acc_pend),
        .cap_idx  (recv_cnt[3:0]),
        .cap_last (cap_last),
        .cap_word (sram_rdata),
        .line     (mem_acc_read_data)
    );

endmodule

// File: tb/tb_acc_mem_responder.sv
// Scoreboard bench for acc_mem_responder with a behavioural 1-cycle-latency SRAM.
module tb_acc_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_en, cpu_we;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         cpu_rvalid;
    logic         mem_acc_read_en;
    logic [15:0]  mem_acc_read_addr;
    logic [511:0] mem_acc_read_data;
    logic         mem_acc_read_data_valid;
    logic         mem_acc_write_en;
    logic [15:0]  mem_acc_write_addr;
    logic [31:0]  mem_acc_write_data;
    logic         mem_acc_write_done;
    logic         mem_listen_en;
    logic [15:0]  mem_listen_addr;
    logic [31:0]  mem_listen_data;
    logic         sram_en, sram_we;
    logic [15:0]  sram_addr;
    logic [31:0]  sram_wdata, sram_rdata;
    logic         req_overflow;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [511:0] data; int cyc; } line_exp_t;
    typedef struct { logic [15:0] addr; logic [31:0] data; int cyc; } word_exp_t;

    line_exp_t rd_q[$];
    word_exp_t cpu_q[$], listen_q[$], sw_q[$];
    int        wd_q[$];
    logic [31:0] wmap [logic [15:0]];

    acc_mem_responder #(.LISTEN_LO(16'h0010), .LISTEN_HI(16'h001F)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_acc_read_en(mem_acc_read_en), .mem_acc_read_addr(mem_acc_read_addr),
        .mem_acc_read_data(mem_acc_read_data), .mem_acc_read_data_valid(mem_acc_read_data_valid),
        .mem_acc_write_en(mem_acc_write_en), .mem_acc_write_addr(mem_acc_write_addr),
        .mem_acc_write_data(mem_acc_write_data), .mem_acc_write_done(mem_acc_write_done),
        .mem_listen_en(mem_listen_en), .mem_listen_addr(mem_listen_addr),
        .mem_listen_data(mem_listen_data),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .req_overflow(req_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Background content: 0x0100..0x010F hold 1..16, everything else is tagged with its address.
    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (a >= 16'h0100 && a <= 16'h010F) return 32'(a - 16'h0100) + 32'd1;
        return {16'hA5A5, a};
    endfunction

    function automatic logic [511:0] exp_line(input logic [15:0] start);
        logic [511:0] l = '0;
        for (int k = 0; k < 16; k++) l[(15 - k) * 32 +: 32] = word_at(start + 16'(k));
        return l;
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) wmap[sram_addr] = sram_wdata;
            else sram_rdata <= wmap.exists(sram_addr) ? wmap[sram_addr] : word_at(sram_addr);
        end
    end

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pending();
        return rd_q.size() + cpu_q.size() + listen_q.size() + sw_q.size() + wd_q.size();
    endfunction

    always @(negedge clk) begin
        line_exp_t le;
        word_exp_t we;
        int        wc;
        if (rst_n === 1'b1) begin
            if (mem_acc_read_data_valid) begin
                check_val("rd_expected", 512'(rd_q.size() != 0), 512'(1));
                if (rd_q.size() != 0) begin
                    le = rd_q.pop_front();
                    check_val("rd_data", mem_acc_read_data, le.data);
                    check_val("rd_cycle", 512'(cyc), 512'(le.cyc));
                end
            end
            if (cpu_rvalid) begin
                check_val("cpu_expected", 512'(cpu_q.size() != 0), 512'(1));
                if (cpu_q.size() != 0) begin
                    we = cpu_q.pop_front();
                    check_val("cpu_rdata", 512'(cpu_rdata), 512'(we.data));
                    check_val("cpu_cycle", 512'(cyc), 512'(we.cyc));
                end
            end
            if (mem_listen_en) begin
                check_val("listen_expected", 512'(listen_q.size() != 0), 512'(1));
                if (listen_q.size() != 0) begin
                    we = listen_q.pop_front();
                    check_val("listen_addr", 512'(mem_listen_addr), 512'(we.addr));
                    check_val("listen_data", 512'(mem_listen_data), 512'(we.data));
                    check_val("listen_cycle", 512'(cyc), 512'(we.cyc));
                end
            end
            if (sram_en && sram_we && !cpu_en) begin
                check_val("accwr_expected", 512'(sw_q.size() != 0), 512'(1));
                if (sw_q.size() != 0) begin
                    we = sw_q.pop_front();
                    check_val("accwr_addr", 512'(sram_addr), 512'(we.addr));
                    check_val("accwr_data", 512'(sram_wdata), 512'(we.data));
                    check_val("accwr_cycle", 512'(cyc), 512'(we.cyc));
                end
            end
            if (mem_acc_write_done) begin
                check_val("wdone_expected", 512'(wd_q.size() != 0), 512'(1));
                if (wd_q.size() != 0) begin
                    wc = wd_q.pop_front();
                    check_val("wdone_cycle", 512'(cyc), 512'(wc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_read(input logic [15:0] a, input bit expect_line, input int lat);
        mem_acc_read_en   = 1'b1;
        mem_acc_read_addr = a;
        if (expect_line) rd_q.push_back('{exp_line(a), cyc + lat});
        tick();
        mem_acc_read_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [31:0] d);
        cpu_en   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        cpu_q.push_back('{a, d, cyc + 1});
        tick();
        cpu_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input bit mirrored);
        cpu_en    = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        if (mirrored) listen_q.push_back('{a, d, cyc + 1});
        tick();
        cpu_en = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (pending() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_val("drain", 512'(pending()), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_acc_read_en = 1'b0; mem_acc_read_addr = '0;
        mem_acc_write_en = 1'b0; mem_acc_write_addr = '0; mem_acc_write_data = '0;
        repeat (3) tick();
        check_val("rst_line", mem_acc_read_data, 512'(0));
        check_val("rst_valid", 512'(mem_acc_read_data_valid), 512'(0));
        check_val("rst_overflow", 512'(req_overflow), 512'(0));
        check_val("rst_sram_en", 512'(sram_en), 512'(0));
        rst_n = 1'b1;
        tick();

        // Uncontended line read
        pulse_read(16'h0100, 1'b1, 19);
        drain();
        check_val("t1_word0", 512'(mem_acc_read_data[511:480]), 512'(1));
        check_val("t1_word15", 512'(mem_acc_read_data[31:0]), 512'(16));

        // Same read stalled by three CPU reads
        pulse_read(16'h0100, 1'b1, 22);
        repeat (3) tick();
        cpu_read(16'h0200, 32'hA5A5_0200);
        cpu_read(16'h0105, 32'd6);
        cpu_read(16'hFFFF, 32'hA5A5_FFFF);
        drain();

        // Address wrap; previous line must stay visible until this one completes
        pulse_read(16'hFFF8, 1'b1, 19);
        repeat (10) tick();
        check_val("t3_hold", mem_acc_read_data, exp_line(16'h0100));
        drain();

        // Lone write
        mem_acc_write_en = 1'b1; mem_acc_write_addr = 16'h0050; mem_acc_write_data = 32'h1234_5678;
        sw_q.push_back('{16'h0050, 32'h1234_5678, cyc + 2});
        wd_q.push_back(cyc + 3);
        tick();
        mem_acc_write_en = 1'b0;
        drain();
        cpu_read(16'h0050, 32'h1234_5678);
        drain();

        // Read and write in the same cycle: read first
        mem_acc_read_en = 1'b1; mem_acc_read_addr = 16'h0100;
        mem_acc_write_en = 1'b1; mem_acc_write_addr = 16'h0040; mem_acc_write_data = 32'hDEAD_BEEF;
        rd_q.push_back('{exp_line(16'h0100), cyc + 19});
        sw_q.push_back('{16'h0040, 32'hDEAD_BEEF, cyc + 21});
        wd_q.push_back(cyc + 22);
        tick();
        mem_acc_read_en = 1'b0;
        mem_acc_write_en = 1'b0;
        drain();
        cpu_read(16'h0040, 32'hDEAD_BEEF);
        drain();

        // Listen window 0x10..0x1F
        cpu_write(16'h000F, 32'h0000_000F, 1'b0);
        cpu_write(16'h0010, 32'h1111_0010, 1'b1);
        cpu_write(16'h001F, 32'h2222_001F, 1'b1);
        cpu_write(16'h0020, 32'h3333_0020, 1'b0);
        drain();

        // Slot refill during READ, then overflow on a third pulse
        pulse_read(16'h0100, 1'b1, 19);
        repeat (3) tick();
        pulse_read(16'h0108, 1'b1, 34);
        tick();
        check_val("ovf_before", 512'(req_overflow), 512'(0));
        pulse_read(16'h0300, 1'b0, 0);
        check_val("ovf_after", 512'(req_overflow), 512'(1));
        drain();

        // Asynchronous reset in the middle of a line read
        pulse_read(16'h0100, 1'b0, 0);
        repeat (8) tick();
        #2;
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 32'hCAFE_F00D;
        rst_n = 1'b0;
        #1;
        check_val("arst_line", mem_acc_read_data, 512'(0));
        check_val("arst_overflow", 512'(req_overflow), 512'(0));
        check_val("arst_listen_en", 512'(mem_listen_en), 512'(0));
        check_val("arst_listen_addr", 512'(mem_listen_addr), 512'(0));
        check_val("arst_listen_data", 512'(mem_listen_data), 512'(0));
        check_val("arst_rvalid", 512'(cpu_rvalid), 512'(0));
        check_val("arst_sram_en", 512'(sram_en), 512'(0));
        check_val("arst_sram_we", 512'(sram_we), 512'(0));
        check_val("arst_sram_addr", 512'(sram_addr), 512'(0));
        check_val("arst_sram_wdata", 512'(sram_wdata), 512'(0));
        check_val("arst_valid", 512'(mem_acc_read_data_valid), 512'(0));
        check_val("arst_wdone", 512'(mem_acc_write_done), 512'(0));
        tick();
        tick();
        cpu_en = 1'b0; cpu_we = 1'b0;
        rst_n = 1'b1;
        repeat (40) tick();
        check_val("post_rst_line", mem_acc_read_data, 512'(0));
        check_val("post_rst_overflow", 512'(req_overflow), 512'(0));
        check_val("post_rst_pending", 512'(pending()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
